fg_phase_accumulator: RTL and testbench

// - NCO front end of the function generator: accumulates a frequency tuning word and emits a

---
 rtl/fg_pkg.sv | 21 ++
 rtl/fg_prescaler.sv | 33 +++
 rtl/fg_phase_accumulator.sv | 98 +++++++++
 tb/tb_fg_phase_accumulator.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fg_pkg.sv
// Shared constants for the function-generator NCO front end: phase scaling,
// CORDIC pipeline depth and the dither LFSR definition.
package fg_pkg;

    localparam int ACC_WIDTH_DEF   = 24;
    localparam int BITWIDTH_PHASE  = 10;
    localparam int PRESC_WIDTH_DEF = 16;
    localparam int CORDIC_LATENCY  = 8;

    // 2^BITWIDTH_PHASE is one full turn, so a quarter turn is 2^(BITWIDTH_PHASE-2)
    localparam int PHASE_90 = 1 << (BITWIDTH_PHASE - 2);

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/fg_prescaler.sv
// Clock-enable prescaler: emits a tick every prescaler_i+1 enabled clocks.
// sync_i restarts the count and suppresses the tick of that cycle.
module fg_prescaler #(
    parameter int PRESC_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   enable_i,
    input  logic                   sync_i,
    input  logic [PRESC_WIDTH-1:0] prescaler_i,
    output logic                   tick_o
);

    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic                   tick_raw;

    // >= rather than == so that lowering prescaler_i below the count ticks at once
    assign tick_raw = enable_i && (presc_cnt >= prescaler_i);
    assign tick_o   = tick_raw && !sync_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            presc_cnt <= '0;
        end else if (sync_i) begin
            presc_cnt <= '0;
        end else if (tick_raw) begin
            presc_cnt <= '0;
        end else if (enable_i) begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fg_phase_accumulator.sv
// NCO front end: accumulates the tuning word, drives phase and clock enable into
// the CORDIC and tracks its pipeline fill. FG_PHASE_DITHER_EN adds LFSR phase dither.
module fg_phase_accumulator
    import fg_pkg::*;
#(
    parameter int ACC_WIDTH      = ACC_WIDTH_DEF,
    parameter int BITWIDTH_PHASE = fg_pkg::BITWIDTH_PHASE,
    parameter int PRESC_WIDTH    = PRESC_WIDTH_DEF,
    parameter int CORDIC_LATENCY = fg_pkg::CORDIC_LATENCY
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic                             enable_i,
    input  logic                             sync_i,
    input  logic [ACC_WIDTH-1:0]             freq_word_i,
    input  logic [BITWIDTH_PHASE-1:0]        phase_offset_i,
    input  logic [PRESC_WIDTH-1:0]           prescaler_i,
    output logic                             clk_en_o,
    output logic signed [BITWIDTH_PHASE-1:0] phase_o,
    output logic                             wrap_o,
    output logic                             sample_valid_o,
    output logic                             sample_strobe_o
);

    localparam int                   FILL_W   = $clog2(CORDIC_LATENCY + 2);
    localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(CORDIC_LATENCY + 1);

    logic                      tick;
    logic [ACC_WIDTH-1:0]      acc;
    logic [ACC_WIDTH-1:0]      acc_src;
    logic [ACC_WIDTH:0]        acc_sum;
    logic [BITWIDTH_PHASE-1:0] phase_nxt;
    logic [FILL_W-1:0]         fill_cnt;

    fg_prescaler #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_presc (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .enable_i    (enable_i),
        .sync_i      (sync_i),
        .prescaler_i (prescaler_i),
        .tick_o      (tick)
    );

    assign acc_sum = {1'b0, acc} + {1'b0, freq_word_i};

`ifdef FG_PHASE_DITHER_EN
    localparam int DW = ACC_WIDTH - BITWIDTH_PHASE;  // must not exceed 16

    logic [15:0] lfsr;

    // dither only perturbs the truncated bits; carry beyond the accumulator is dropped
    assign acc_src = acc + ACC_WIDTH'(lfsr[DW-1:0]);

    always_ff @(posedge clk_i) begin
        if (!rstn_i || sync_i) begin
            lfsr <= LFSR_SEED;
        end else if (tick) begin
            lfsr <= lfsr_next(lfsr);
        end
    end
`else
    assign acc_src = acc;
`endif

    assign phase_nxt      = acc_src[ACC_WIDTH-1 -: BITWIDTH_PHASE] + phase_offset_i;
    assign sample_valid_o = (fill_cnt == FILL_MAX);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            acc             <= '0;
            fill_cnt        <= '0;
            phase_o         <= '0;
            clk_en_o        <= 1'b0;
            wrap_o          <= 1'b0;
            sample_strobe_o <= 1'b0;
        end else if (sync_i) begin
            // phase_o deliberately holds so the CORDIC input stays quiet until the next tick
            acc             <= '0;
            fill_cnt        <= '0;
            clk_en_o        <= 1'b0;
            wrap_o          <= 1'b0;
            sample_strobe_o <= 1'b0;
        end else begin
            clk_en_o        <= tick;
            wrap_o          <= tick && acc_sum[ACC_WIDTH];
            sample_strobe_o <= enable_i && clk_en_o && sample_valid_o;
            if (tick) begin
                phase_o <= phase_nxt;
                acc     <= acc_sum[ACC_WIDTH-1:0];
                if (fill_cnt != FILL_MAX)
                    fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fg_phase_accumulator.sv
// Directed bench for fg_phase_accumulator (default build, no dither).
module tb_fg_phase_accumulator;

    logic        clk_i = 1'b0;
    logic        rstn_i, enable_i, sync_i;
    logic [23:0] freq_word_i;
    logic [9:0]  phase_offset_i;
    logic [15:0] prescaler_i;
    logic        clk_en_o, wrap_o, sample_valid_o, sample_strobe_o;
    logic [9:0]  phase_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    fg_phase_accumulator dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .enable_i        (enable_i),
        .sync_i          (sync_i),
        .freq_word_i     (freq_word_i),
        .phase_offset_i  (phase_offset_i),
        .prescaler_i     (prescaler_i),
        .clk_en_o        (clk_en_o),
        .phase_o         (phase_o),
        .wrap_o          (wrap_o),
        .sample_valid_o  (sample_valid_o),
        .sample_strobe_o (sample_strobe_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int wraps;
        int n_en;
        logic [9:0] prev;

        rstn_i = 1'b0; enable_i = 1'b1; sync_i = 1'b0;
        freq_word_i = '0; phase_offset_i = '0; prescaler_i = '0;
        step(); step();
        chk("rst_phase",  32'(phase_o), 0);
        chk("rst_clk_en", 32'(clk_en_o), 0);
        chk("rst_wrap",   32'(wrap_o), 0);
        chk("rst_valid",  32'(sample_valid_o), 0);
        chk("rst_strobe", 32'(sample_strobe_o), 0);

        // ramp: one phase LSB per tick, single wrap after 1024 ticks
        rstn_i = 1'b1; freq_word_i = 24'd16384; sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        chk("sync_clk_en", 32'(clk_en_o), 0);
        wraps = 0;
        for (int k = 1; k <= 1030; k++) begin
            step();
            if (wrap_o) wraps++;
            if (k <= 12) begin
                chk("ramp_phase",  32'(phase_o), 32'(k - 1));
                chk("ramp_clk_en", 32'(clk_en_o), 1);
                chk("ramp_valid",  32'(sample_valid_o), (k >= 9) ? 1 : 0);
                chk("ramp_strobe", 32'(sample_strobe_o), (k >= 10) ? 1 : 0);
            end
            if (k == 1024) begin
                chk("wrap_pulse", 32'(wrap_o), 1);
                chk("wrap_phase", 32'(phase_o), 1023);
            end
            if (k == 1025) chk("after_wrap_phase", 32'(phase_o), 0);
        end
        chk("wrap_count", 32'(wraps), 1);

        // prescaler 3: one enable in four, phase moves only with it
        prescaler_i = 16'd3; sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        prev = phase_o;
        n_en = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (clk_en_o) n_en++;
            else chk("presc_hold", 32'(phase_o), 32'(prev));
            prev = phase_o;
        end
        chk("presc_count", 32'(n_en), 4);
        chk("presc_phase", 32'(phase_o), 3);

        // lowering prescaler below the running count ticks immediately
        prescaler_i = 16'd7; sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("presc7_idle", 32'(clk_en_o), 0);
        end
        prescaler_i = 16'd2;
        step();
        chk("presc_lower_tick", 32'(clk_en_o), 1);

        // fw=0: phase sits at the offset
        prescaler_i = '0; freq_word_i = '0; phase_offset_i = 10'd256; sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        step();
        chk("off256_a", 32'(phase_o), 256);
        step();
        chk("off256_b", 32'(phase_o), 256);
        phase_offset_i = 10'd768;
        step();
        chk("off768_signed", 32'($signed(phase_o)), -32'sd256);

        // odd tuning word plus offset, wrapping mod 1024
        freq_word_i = 24'h123456; phase_offset_i = 10'd1000; sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        step(); chk("odd_fw_0", 32'(phase_o), 1000);
        step(); chk("odd_fw_1", 32'(phase_o), 48);
        step(); chk("odd_fw_2", 32'(phase_o), 121);

        // enable low freezes everything, resume continues
        freq_word_i = 24'd16384; phase_offset_i = '0; sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("pre_pause_phase", 32'(phase_o), 4);
        enable_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pause_clk_en", 32'(clk_en_o), 0);
            chk("pause_phase",  32'(phase_o), 4);
        end
        enable_i = 1'b1;
        step();
        chk("resume_phase",  32'(phase_o), 5);
        chk("resume_clk_en", 32'(clk_en_o), 1);

        // sync coinciding with a tick: no tick, phase holds
        sync_i = 1'b1;
        step();
        chk("synctick_clk_en", 32'(clk_en_o), 0);
        chk("synctick_phase",  32'(phase_o), 5);
        sync_i = 1'b0; phase_offset_i = 10'd3;
        step();
        chk("post_sync_phase", 32'(phase_o), 3);

        // reset mid-run with pipeline filled
        for (int i = 0; i < 11; i++) step();
        chk("prerst_valid", 32'(sample_valid_o), 1);
        chk("prerst_strobe", 32'(sample_strobe_o), 1);
        rstn_i = 1'b0;
        step();
        chk("midrst_phase",  32'(phase_o), 0);
        chk("midrst_clk_en", 32'(clk_en_o), 0);
        chk("midrst_valid",  32'(sample_valid_o), 0);
        chk("midrst_strobe", 32'(sample_strobe_o), 0);
        chk("midrst_wrap",   32'(wrap_o), 0);
        rstn_i = 1'b1;
        step();
        chk("postrst_phase", 32'(phase_o), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
